// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results take priority; load returns queue in a
// small FIFO and drain in idle slots. A younger ALU write to the same register kills stale loads.
module rf_writeback_arbiter #(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int WORD_BITWIDTH    = 32,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            alu_valid,
   input  logic [REG_NUM_BITWIDTH-1:0]     alu_rd,
   input  logic [WORD_BITWIDTH-1:0]        alu_data,
   input  logic                            mem_valid,
   output logic                            mem_ready,
   input  logic [REG_NUM_BITWIDTH-1:0]     mem_rd,
   input  logic [WORD_BITWIDTH-1:0]        mem_data,
   output logic                            rf_wr_en,
   output logic [REG_NUM_BITWIDTH-1:0]     rf_wr_addr,
   output logic [WORD_BITWIDTH-1:0]        rf_wr_data,
   output logic [2**REG_NUM_BITWIDTH-1:0]  pend_mask,
   output logic                            fifo_empty
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [FIFO_DEPTH-1:0]                       ent_live;
   logic [FIFO_DEPTH-1:0][REG_NUM_BITWIDTH-1:0] ent_rd;
   logic [FIFO_DEPTH-1:0][WORD_BITWIDTH-1:0]    ent_data;
   logic [AW-1:0] head, tail;
   logic [AW:0]   count;
   logic          full, alu_wr, pop, push, head_wr;

   assign full       = (count == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign mem_ready  = !full;
   assign alu_wr     = alu_valid && (alu_rd != '0);
   assign pop        = !alu_wr && !fifo_empty;
   assign head_wr    = pop && ent_live[head];
   // A load racing a same-register ALU write is older, so it is simply discarded.
   assign push       = mem_valid && !full && (mem_rd != '0) && !(alu_wr && (mem_rd == alu_rd));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_live   <= '0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            if (alu_wr && (ent_rd[i] == alu_rd)) ent_live[i] <= 1'b0;
         if (pop) begin
            ent_live[head] <= 1'b0;
            head           <= head + AW'(1);
         end
         if (push) begin
            ent_live[tail] <= 1'b1;
            tail           <= tail + AW'(1);
         end
         count    <= count + (AW+1)'(push) - (AW+1)'(pop);
         rf_wr_en <= alu_wr || head_wr;
         if (alu_wr) begin
            rf_wr_addr <= alu_rd;
            rf_wr_data <= alu_data;
         end else if (head_wr) begin
            rf_wr_addr <= ent_rd[head];
            rf_wr_data <= ent_data[head];
         end
      end
   end

   // Payload storage needs no reset; liveness alone decides validity.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_rd[tail]   <= mem_rd;
         ent_data[tail] <= mem_data;
      end
   end

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (ent_live[i]) pend_mask[ent_rd[i]] = 1'b1;
   end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_rf_writeback_arbiter;
   localparam int DEPTH = 4;

   logic        clk, rst;
   logic        alu_valid, mem_valid, mem_ready, rf_wr_en, fifo_empty;
   logic [4:0]  alu_rd, mem_rd, rf_wr_addr;
   logic [31:0] alu_data, mem_data, rf_wr_data, pend_mask;

   rf_writeback_arbiter #(.REG_NUM_BITWIDTH(5), .WORD_BITWIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .pend_mask(pend_mask), .fifo_empty(fifo_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { bit live; bit [4:0] rd; bit [31:0] data; } ent_t;
   typedef struct {
      bit av; bit [4:0] ard; bit [31:0] ad;
      bit mv; bit [4:0] mrd; bit [31:0] md;
      bit rdy; bit empty; bit [31:0] pm;   // before the edge
      bit en; bit [4:0] addr; bit [31:0] data; // after the edge
   } vec_t;

   ent_t        m_q[$];
   bit          m_en;
   bit [4:0]    m_addr;
   bit [31:0]   m_data;
   bit [4:0]    wlog[$];
   int          total = 0, bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_en = 0; m_addr = 0; m_data = 0;
   endtask

   // One clock: drive, check combinational outputs against the model, advance, check rf_wr_*.
   task automatic drive(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                        input bit mv, input bit [4:0] mrd, input bit [31:0] md,
                        output bit acc, output bit rdy_s, output bit empty_s, output bit [31:0] pm_s);
      bit [31:0] pm;
      bit rdy, aw;
      ent_t e;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      #1;
      pm = 0;
      foreach (m_q[i]) if (m_q[i].live) pm[m_q[i].rd] = 1'b1;
      rdy = (m_q.size() < DEPTH);
      rdy_s = mem_ready; empty_s = fifo_empty; pm_s = pend_mask;
      check("mem_ready", mem_ready, rdy);
      check("fifo_empty", fifo_empty, m_q.size() == 0);
      check("pend_mask", pend_mask, pm);
      acc = mv && rdy;
      aw = av && (ard != 0);
      if (aw) begin
         foreach (m_q[i]) if (m_q[i].rd == ard) m_q[i].live = 0;
         m_en = 1; m_addr = ard; m_data = ad;
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         m_en = e.live;
         if (e.live) begin m_addr = e.rd; m_data = e.data; end
      end else m_en = 0;
      if (acc && mrd != 0 && !(aw && mrd == ard)) m_q.push_back('{1'b1, mrd, md});
      @(posedge clk); #1;
      check("rf_wr_en", rf_wr_en, m_en);
      check("rf_wr_addr", rf_wr_addr, m_addr);
      check("rf_wr_data", rf_wr_data, m_data);
      if (rf_wr_en) wlog.push_back(rf_wr_addr);
   endtask

   task automatic idle(input int n);
      bit a, r, em; bit [31:0] p;
      for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, a, r, em, p);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      #12;
      check("reset rf_wr_en", rf_wr_en, 0);
      check("reset rf_wr_addr", rf_wr_addr, 0);
      check("reset rf_wr_data", rf_wr_data, 0);
      check("reset pend_mask", pend_mask, 0);
      check("reset fifo_empty", fifo_empty, 1);
      check("reset mem_ready", mem_ready, 1);
      @(negedge clk); rst = 1'b0;
      model_clear();
      @(posedge clk); #1;
   endtask

   vec_t vt[9];

   initial begin
      bit a, r, em; bit [31:0] p;
      int j;
      bit [4:0] exp_w[$];

      vt[0] = '{1,5,32'hDEADBEEF, 0,0,0,     1,1,0,       1,5,32'hDEADBEEF};
      vt[1] = '{0,0,0,            0,0,0,     1,1,0,       0,5,32'hDEADBEEF};
      vt[2] = '{0,0,0,            1,7,32'h11,1,1,0,       0,5,32'hDEADBEEF};
      vt[3] = '{0,0,0,            0,0,0,     1,0,32'h80,  1,7,32'h11};
      vt[4] = '{0,0,0,            0,0,0,     1,1,0,       0,7,32'h11};
      vt[5] = '{1,0,32'h55,       1,0,32'h66,1,1,0,       0,7,32'h11};
      vt[6] = '{0,0,0,            0,0,0,     1,1,0,       0,7,32'h11};
      vt[7] = '{1,9,32'h99,       1,9,32'h77,1,1,0,       1,9,32'h99};
      vt[8] = '{0,0,0,            0,0,0,     1,1,0,       0,9,32'h99};

      do_reset();

      // Table: single ALU write, single load, x0 handling, same-register race.
      for (int i = 0; i < 9; i++) begin
         drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].mv, vt[i].mrd, vt[i].md, a, r, em, p);
         check($sformatf("vec%0d ready", i), r, vt[i].rdy);
         check($sformatf("vec%0d empty", i), em, vt[i].empty);
         check($sformatf("vec%0d pmask", i), p, vt[i].pm);
         check($sformatf("vec%0d en", i), rf_wr_en, vt[i].en);
         check($sformatf("vec%0d addr", i), rf_wr_addr, vt[i].addr);
         check($sformatf("vec%0d data", i), rf_wr_data, vt[i].data);
      end

      // ALU burst starves FIFO; fifth load waits for space; loads drain in order.
      wlog.delete(); j = 0;
      for (int c = 0; c < 20; c++) begin
         drive(c < 6, 5'(c + 1), 32'h100 + c, j < 5, 5'(10 + j), 32'h200 + j, a, r, em, p);
         if (c == 4) check("burst ready low after 4 pushes", r, 0);
         if (a) j++;
      end
      check("burst all loads accepted", j, 5);
      check("burst fifo_empty end", fifo_empty, 1);
      exp_w = '{1, 2, 3, 4, 5, 6, 10, 11, 12, 13, 14};
      check("burst write count", wlog.size(), exp_w.size());
      foreach (exp_w[i]) if (i < wlog.size()) check($sformatf("burst write%0d", i), wlog[i], exp_w[i]);

      // Buffered r3 load killed by younger ALU write to r3.
      wlog.delete();
      drive(1, 1, 32'h1, 1, 3, 32'hAA, a, r, em, p);
      drive(1, 3, 32'hBB, 0, 0, 0, a, r, em, p);
      check("kill pmask before", p, 32'h8);
      check("kill alu data", rf_wr_data, 32'hBB);
      drive(0, 0, 0, 0, 0, 0, a, r, em, p);
      check("kill pmask after", p, 0);
      check("kill head no write", rf_wr_en, 0);
      check("kill data kept", rf_wr_data, 32'hBB);
      idle(1);
      check("kill fifo drained", fifo_empty, 1);

      // Asynchronous reset with two entries buffered.
      drive(1, 1, 32'h1, 1, 4, 32'h44, a, r, em, p);
      drive(1, 2, 32'h2, 1, 6, 32'h66, a, r, em, p);
      check("rst pre pmask", pend_mask, 32'h50);
      alu_valid = 0; mem_valid = 0;
      #2 rst = 1'b1;
      #1;
      check("async rst en", rf_wr_en, 0);
      check("async rst addr", rf_wr_addr, 0);
      check("async rst data", rf_wr_data, 0);
      check("async rst pmask", pend_mask, 0);
      check("async rst empty", fifo_empty, 1);
      check("async rst ready", mem_ready, 1);
      #2 rst = 1'b0;
      model_clear();
      @(posedge clk); #1;
      wlog.delete();
      idle(4);
      check("no writes after rst", wlog.size(), 0);

      // Random traffic against the model; small register range forces collisions.
      for (int c = 0; c < 400; c++)
         drive($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom, a, r, em, p);
      idle(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
